// File: rtl/data_dispatch.sv
// Round-robin dispatcher: reads one interleaved upstream FIFO word at a time and writes it
// to the matching per-channel FIFO. Optional macro HEADER_ALIGN_EN enables channel-0 header alignment.
module data_dispatch #(
    parameter int ADC_CHANEL = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk_200m,
    input  logic                             reset,
    input  logic                             fifo_empty,
    output logic                             fifo_rden,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [ADC_CHANEL-1:0]            fifo_full,
    output logic [ADC_CHANEL-1:0]            fifo_wren,
    output logic [ADC_CHANEL*DATA_WIDTH-1:0] data_out,
    output logic [15:0]                      frame_cnt,
    output logic                             sync_err
);

    localparam int CW = $clog2(ADC_CHANEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        LATCH = 2'd2,
        NEXT  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_channel_sel;
    logic                    r_fifo_rden;
    logic [ADC_CHANEL-1:0]   r_fifo_wren;
    logic [15:0]             r_frame_cnt;
    logic                    r_sync_err;
    logic                    w_hdr_ok;
    logic                    w_last_ch;
    logic [ADC_CHANEL-1:0]   w_sel_onehot;

`ifdef HEADER_ALIGN_EN
    // Only the first word of a frame carries the 0xAA55 marker.
    assign w_hdr_ok = (r_channel_sel != '0) || (data_in[31:16] == 16'hAA55);
`else
    assign w_hdr_ok = 1'b1;
`endif

    assign w_last_ch    = (r_channel_sel == CW'(ADC_CHANEL - 1));
    assign w_sel_onehot = {{(ADC_CHANEL-1){1'b0}}, 1'b1} << r_channel_sel;

    always_ff @(posedge clk_200m or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_channel_sel <= '0;
            r_fifo_rden   <= 1'b0;
            r_fifo_wren   <= '0;
            r_frame_cnt   <= 16'd0;
            r_sync_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fifo_wren <= '0;
                    // Full is checked before reading so an accepted word always has room.
                    if (!fifo_empty && !fifo_full[r_channel_sel]) begin
                        r_fifo_rden <= 1'b1;
                        r_state     <= RD;
                    end else begin
                        r_fifo_rden <= 1'b0;
                    end
                end
                RD: begin
                    r_fifo_rden <= 1'b0;
                    r_state     <= LATCH;
                end
                LATCH: begin
                    r_fifo_wren <= w_hdr_ok ? w_sel_onehot : '0;
                    r_sync_err  <= !w_hdr_ok;
                    r_state     <= NEXT;
                end
                NEXT: begin
                    r_fifo_wren <= '0;
                    r_sync_err  <= 1'b0;
                    // A rejected header leaves channel_sel at 0 to wait for the next header.
                    if (!r_sync_err) begin
                        if (w_last_ch) begin
                            r_channel_sel <= '0;
                            r_frame_cnt   <= r_frame_cnt + 16'd1;
                        end else begin
                            r_channel_sel <= r_channel_sel + 1'b1;
                        end
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_fifo_rden <= 1'b0;
                    r_fifo_wren <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ADC_CHANEL; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] r_lane;

            always_ff @(posedge clk_200m or negedge reset) begin
                if (!reset) begin
                    r_lane <= '0;
                end else if (r_state == LATCH && r_channel_sel == CW'(gi) && w_hdr_ok) begin
                    r_lane <= data_in;
                end
            end

            assign data_out[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH] = r_lane;
        end
    endgenerate

    assign fifo_rden = r_fifo_rden;
    assign fifo_wren = r_fifo_wren;
    assign frame_cnt = r_frame_cnt;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_data_dispatch.sv
// Scoreboard bench for data_dispatch: directed word streams, upstream FIFO model, wren monitor.
module tb_data_dispatch;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic                clk_200m = 1'b0;
    logic                reset;
    logic                fifo_empty;
    logic                fifo_rden;
    logic [DW-1:0]       data_in;
    logic [NCH-1:0]      fifo_full;
    logic [NCH-1:0]      fifo_wren;
    logic [NCH*DW-1:0]   data_out;
    logic [15:0]         frame_cnt;
    logic                sync_err;

    data_dispatch #(.ADC_CHANEL(NCH), .DATA_WIDTH(DW)) dut (
        .clk_200m  (clk_200m),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_rden (fifo_rden),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .fifo_wren (fifo_wren),
        .data_out  (data_out),
        .frame_cnt (frame_cnt),
        .sync_err  (sync_err)
    );

    always #5 clk_200m = ~clk_200m;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] up_q[$];
    int          n_vec   = 0;
    int          n_err   = 0;
    int          rd_cnt  = 0;
    int          wr_cnt  = 0;
    int          se_cnt  = 0;
    bit          tog_en  = 1'b0;
    bit          tog_ph  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int ch, input bit expect_write);
        exp_t e;
        up_q.push_back(w);
        if (expect_write) begin
            e.ch = ch;
            e.d  = w;
            sb_q.push_back(e);
        end
    endtask

    // Upstream FIFO model: data follows rden, empty flag optionally toggled each cycle.
    initial begin
        fifo_empty = 1'b1;
        data_in    = '0;
        forever begin
            @(negedge clk_200m);
            if (fifo_rden) begin
                rd_cnt++;
                chk("rden_not_empty", {63'd0, fifo_empty}, 64'd0);
                if (up_q.size() == 0) chk("rden_underflow", 64'd1, 64'd0);
                else data_in = up_q.pop_front();
            end
            fifo_empty = (up_q.size() == 0) || (tog_en && tog_ph);
            tog_ph     = ~tog_ph;
        end
    end

    // Monitor: every write strobe is matched against the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk_200m);
            if (sync_err) se_cnt++;
            if (reset && fifo_wren != '0) begin
                int   k;
                exp_t e;
                k = 0;
                wr_cnt++;
                for (int i = 0; i < NCH; i++) if (fifo_wren[i]) k = i;
                chk("wren_onehot", 64'($countones(fifo_wren)), 64'd1);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_channel", 64'(k), 64'(e.ch));
                    chk("wr_data", {32'd0, data_out[k*DW +: DW]}, {32'd0, e.d});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_200m);
        reset = 1'b0;
        repeat (2) @(negedge clk_200m);
        reset = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((up_q.size() != 0 || sb_q.size() != 0) && n < 500) begin
            @(negedge clk_200m);
            n++;
        end
        if (n >= 500) chk({name, "_timeout"}, 64'd1, 64'd0);
        repeat (3) @(negedge clk_200m);
    endtask

    initial begin
        int rd0;
        int wr0;
        int n;
        reset     = 1'b0;
        fifo_full = '0;
        repeat (3) @(negedge clk_200m);
        chk("rst_rden", {63'd0, fifo_rden}, 64'd0);
        chk("rst_wren", 64'(fifo_wren), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_frame", 64'(frame_cnt), 64'd0);
        chk("rst_sync", {63'd0, sync_err}, 64'd0);
        reset = 1'b1;

        // Two full frames in round-robin order.
        rd0 = rd_cnt;
        push_word(32'hAA55_0000, 0, 1); push_word(32'h0000_0001, 1, 1);
        push_word(32'h0000_0002, 2, 1); push_word(32'h0000_0003, 3, 1);
        push_word(32'hAA55_0004, 0, 1); push_word(32'h0000_0005, 1, 1);
        push_word(32'h0000_0006, 2, 1); push_word(32'h0000_0007, 3, 1);
        wait_done("rr");
        chk("rr_frame", 64'(frame_cnt), 64'd2);
        chk("rr_rden_pulses", 64'(rd_cnt - rd0), 64'd8);

        // Stall on channel 2 full flag.
        do_reset();
        fifo_full = 4'b0100;
        wr0 = wr_cnt;
        push_word(32'hAA55_0020, 0, 1); push_word(32'h0000_0021, 1, 1);
        push_word(32'h0000_0022, 2, 1); push_word(32'h0000_0023, 3, 1);
        n = 0;
        while (wr_cnt - wr0 < 2 && n < 100) begin
            @(negedge clk_200m);
            n++;
        end
        chk("stall_prefix_writes", 64'(wr_cnt - wr0), 64'd2);
        repeat (3) @(negedge clk_200m);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        repeat (20) @(negedge clk_200m);
        chk("stall_no_rden", 64'(rd_cnt - rd0), 64'd0);
        chk("stall_no_wren", 64'(wr_cnt - wr0), 64'd0);
        fifo_full = '0;
        repeat (3) @(posedge clk_200m);
        #1;
        chk("stall_release_wren", 64'(fifo_wren), 64'h4);
        wait_done("stall");
        chk("stall_frame", 64'(frame_cnt), 64'd1);

        // Reset during LATCH of word 1: word 1 is lost, selection restarts at ch0.
        do_reset();
        rd0 = rd_cnt;
        push_word(32'hAA55_0010, 0, 1); push_word(32'h0000_0011, 1, 0);
        push_word(32'hAA55_0012, 0, 0); push_word(32'h0000_0013, 1, 0);
        n = 0;
        while (rd_cnt - rd0 < 2 && n < 100) begin
            @(negedge clk_200m);
            n++;
        end
        chk("mid_rst_second_read", 64'(rd_cnt - rd0), 64'd2);
        @(posedge clk_200m);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_rden", {63'd0, fifo_rden}, 64'd0);
        chk("mid_rst_wren", 64'(fifo_wren), 64'd0);
        chk("mid_rst_data", 64'(data_out), 64'd0);
        chk("mid_rst_frame", 64'(frame_cnt), 64'd0);
        @(negedge clk_200m);
        @(negedge clk_200m);
        sb_q.push_back('{0, 32'hAA55_0012});
        sb_q.push_back('{1, 32'h0000_0013});
        reset = 1'b1;
        wait_done("mid_rst");
        chk("mid_rst_frame_after", 64'(frame_cnt), 64'd0);

        // Empty flag toggling every cycle.
        do_reset();
        tog_en = 1'b1;
        rd0 = rd_cnt;
        push_word(32'hAA55_0030, 0, 1); push_word(32'h0000_0031, 1, 1);
        push_word(32'h0000_0032, 2, 1); push_word(32'h0000_0033, 3, 1);
        push_word(32'hAA55_0034, 0, 1); push_word(32'h0000_0035, 1, 1);
        push_word(32'h0000_0036, 2, 1); push_word(32'h0000_0037, 3, 1);
        wait_done("toggle");
        tog_en = 1'b0;
        chk("toggle_rden_pulses", 64'(rd_cnt - rd0), 64'd8);
        chk("toggle_frame", 64'(frame_cnt), 64'd2);

        // Frame counter wrap from 0xFFFF.
        @(negedge clk_200m);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk_200m);
        release dut.r_frame_cnt;
        @(negedge clk_200m);
        push_word(32'hAA55_0040, 0, 1); push_word(32'h0000_0041, 1, 1);
        push_word(32'h0000_0042, 2, 1); push_word(32'h0000_0043, 3, 1);
        wait_done("wrap");
        chk("wrap_frame", 64'(frame_cnt), 64'd0);

`ifdef HEADER_ALIGN_EN
        // Bad header dropped with one sync_err pulse, then re-alignment.
        do_reset();
        push_word(32'h1234_0000, 0, 0);
        push_word(32'hAA55_0001, 0, 1); push_word(32'h0000_0011, 1, 1);
        push_word(32'h0000_0022, 2, 1); push_word(32'h0000_0033, 3, 1);
        wait_done("hdr");
        chk("hdr_frame", 64'(frame_cnt), 64'd1);
        chk("sync_err_pulses", 64'(se_cnt), 64'd1);
`else
        chk("sync_err_pulses", 64'(se_cnt), 64'd0);
`endif
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_dispatch.md
Name: data_dispatch

Overview:
- Reverse path of the channel-to-stream packer: one upstream 32-bit FIFO carries words interleaved channel 0..ADC_CHANEL-1, repeating.
- The block reads that FIFO one word at a time and writes each word into the matching per-channel downstream FIFO, in round-robin order.
- It sits between the PC-side receive FIFO and the per-ADC-channel configuration/playback FIFOs.

Parameters:
- ADC_CHANEL, 4, number of downstream channels (2..16); need not be a power of two.
- DATA_WIDTH, 32, word width.

Ports:
- clk_200m  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous reset, active-low (0 = reset)
- fifo_empty  input  1  upstream FIFO empty flag
- fifo_rden  output  1  upstream FIFO read enable, one-cycle pulse per word
- data_in  input  DATA_WIDTH  upstream FIFO read data, valid one cycle after fifo_rden
- fifo_full  input  ADC_CHANEL  per-channel downstream FIFO full flags
- fifo_wren  output  ADC_CHANEL  per-channel write enable, one-hot or zero
- data_out  output  ADC_CHANEL*DATA_WIDTH  per-channel write data; lane k = bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- frame_cnt  output  16  completed-frame counter (one frame = ADC_CHANEL words)
- sync_err  output  1  header mismatch pulse (HEADER_ALIGN_EN only)

Behaviour:
- Reset (reset=0, async): state=IDLE, channel_sel=0, fifo_rden=0, fifo_wren=0, data_out=0, frame_cnt=0, sync_err=0. All outputs are registered.
- FSM states: IDLE, RD, LATCH, NEXT.
- IDLE: if fifo_empty==0 and fifo_full[channel_sel]==0, then fifo_rden<=1 and go to RD. Otherwise hold with fifo_rden=0. Full is checked before reading, so words are never dropped.
- RD (fifo_rden high this cycle): fifo_rden<=0, go to LATCH.
- LATCH (data_in valid this cycle):
  - lane[channel_sel] <= data_in.
  - fifo_wren <= 1<<channel_sel.
  - Go to NEXT.
  - Other lanes hold their values.
- NEXT (fifo_wren high this cycle): fifo_wren<=0.
  - If channel_sel==ADC_CHANEL-1: channel_sel<=0 and frame_cnt<=frame_cnt+1.
  - Otherwise channel_sel<=channel_sel+1.
  - Go to IDLE.
- Latency: fifo_rden in cycle N; data_in sampled at end of N+1; fifo_wren high in N+2. Maximum throughput is 1 word per 4 cycles.
- fifo_full or fifo_empty changing outside IDLE is ignored until the next IDLE. A full flag rising after the read has been issued does not abort the write; the downstream FIFO is sized with at least 1 word of slack.
- A stall on one channel's full flag blocks all channels; the round-robin order is never skipped.
- frame_cnt wraps 0xFFFF->0x0000 without a flag.
- Reset mid-operation: a word already read but not yet written is lost. channel_sel returns to 0.
- Undefined state codes go to IDLE with fifo_rden=0 and fifo_wren=0.

Optional Feature:
Macro HEADER_ALIGN_EN.
- Defined:
  - In LATCH with channel_sel==0, if data_in[31:16]!=16'hAA55, no write occurs.
  - sync_err=1 for exactly one cycle (NEXT), and channel_sel stays 0.
  - The block re-aligns on the next header word; frame_cnt is unchanged.
  - A matching header word is written to channel 0 unmodified.
- Not defined: no check; sync_err tied to 0.

Test Plan:
- Reset, then 8 words 0x0000_0000..0x0000_0007 in upstream, all full=0, ADC_CHANEL=4 -> ch0 gets 0,4; ch1 gets 1,5; ch2 gets 2,6; ch3 gets 3,7. frame_cnt=2, exactly 8 fifo_rden pulses, fifo_wren one-hot each time.
- fifo_full[2]=1 held 20 cycles when channel_sel=2 -> fifo_rden stays 0, no wren. After release, word 2 goes to ch2 in the 3rd cycle after release.
- Assert reset in the LATCH cycle of word 1 -> all outputs 0 immediately. After release, the next word goes to ch0; frame_cnt=0.
- Preload frame_cnt to 0xFFFF (4 words fed 65536 times, or force) plus one more frame -> frame_cnt=0x0000.
- fifo_empty toggling each cycle -> each rden issued only from IDLE with fifo_empty=0; no read while empty; word count matches.
- HEADER_ALIGN_EN: stream 0x1234_0000, 0xAA55_0001, 0x11, 0x22, 0x33 -> first word dropped with one sync_err pulse. ch0=0xAA55_0001, ch1..3=0x11,0x22,0x33; frame_cnt=1.
